// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner arbitration for one shared 4-digit seven-segment display.
// Latency: a request seen in IDLE (or on the last GAP cycle) yields gnt plus the latched word on the next cycle.
// Backpressure: level req, no queueing; a requester must drop req within one cycle of gnt or it re-requests.
//
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   req[NREQ]       - level requests, bit i = requester i
//   req_data        - requester i word at [16*i+15:16*i], nibble [15:12] is the leftmost digit
//   idle_data       - word shown while nobody owns the display (IDLE and GAP)
//   gnt             - one-hot single-cycle grant pulse, coincides with the first displayed cycle
//   owner           - index of the current owner, meaningful while busy
//   busy            - high for every SHOW cycle
//   done            - single-cycle pulse on the last SHOW cycle of a non-preempted owner
//   in3..in0        - digit nibbles to the seven-segment driver, in3 is leftmost
//
// Optional build macro SEGARB_PREEMPT_EN: requester 0 becomes urgent and may take the
// display from any other owner (during SHOW) or cut a GAP short. Without it the block
// is purely non-preemptive round-robin.

module seg_display_arbiter #(
    parameter int NREQ         = 3,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int GAP_CYCLES   = 10_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [16*NREQ-1:0]       req_data,
    input  logic [15:0]              idle_data,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               in3,
    output logic [3:0]               in2,
    output logic [3:0]               in1,
    output logic [3:0]               in0
);

    localparam int PW   = $clog2(NREQ);
    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] LAST_IDX   = PW'(NREQ - 1);
    localparam logic          DWELL_ONE  = (DWELL_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [CW-1:0]   cnt_q;      // shared dwell / gap down-counter
    logic [PW-1:0]   rr_q;       // highest-priority requester for the next grant
    logic [15:0]     disp_q;     // word currently driven to the digits

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t          state_d;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   rr_d;
    logic [15:0]     disp_d;
    logic [NREQ-1:0] gnt_d;
    logic [PW-1:0]   owner_d;
    logic            busy_d;
    logic            done_d;

    // Unpack requester words so they can be selected by a narrow index.
    logic [15:0]     words [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign words[gi] = req_data[16*gi +: 16];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first set request scanning upward from rr_q, wrapping.
    // ------------------------------------------------------------------
    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   scan_idx;
    int              scan;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = 0;
        scan_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan = int'(rr_q) + off;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            scan_idx = PW'(scan);
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic            take;       // a grant is issued at this edge
    logic [PW-1:0]   take_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        disp_d   = disp_q;
        gnt_d    = '0;
        owner_d  = owner;
        busy_d   = busy;
        done_d   = 1'b0;
        take     = 1'b0;
        take_idx = pick_idx;

        case (state_q)
            ST_IDLE: begin
                disp_d = idle_data;
                take   = pick_vld;
            end

            ST_SHOW: begin
                if (cnt_q == '0) begin
                    busy_d = 1'b0;
                    disp_d = idle_data;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    // done is registered, so raise it as the counter reaches zero.
                    done_d = (cnt_q == CNT_ONE);
                end
            end

            ST_GAP: begin
                disp_d = idle_data;
                if (cnt_q == '0) begin
                    // The last gap cycle arbitrates exactly as IDLE would, so a
                    // waiting request is granted with no extra dead cycle and
                    // back-to-back owners are DWELL+GAP cycles apart.
                    state_d = ST_IDLE;
                    take    = pick_vld;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SEGARB_PREEMPT_EN
        // Requester 0 may cut in on another owner or on a gap; it never
        // preempts itself. The displaced owner gets no done pulse.
        if (req[0] && (((state_q == ST_SHOW) && (owner != '0)) || (state_q == ST_GAP))) begin
            take     = 1'b1;
            take_idx = '0;
        end
`endif

        if (take) begin
            state_d         = ST_SHOW;
            cnt_d           = DWELL_LOAD;
            gnt_d           = '0;
            gnt_d[take_idx] = 1'b1;
            disp_d          = words[take_idx];
            owner_d         = take_idx;
            busy_d          = 1'b1;
            done_d          = DWELL_ONE;
            rr_d            = (take_idx == LAST_IDX) ? '0 : take_idx + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            disp_q  <= '0;
            gnt     <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            disp_q  <= disp_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign in3 = disp_q[15:12];
    assign in2 = disp_q[11:8];
    assign in1 = disp_q[7:4];
    assign in0 = disp_q[3:0];

endmodule
